// File: rtl/dac_pkg.sv
// dac_pkg: constants and state encoding shared by the DAC write engine.
package dac_pkg;

   // Frame width shared with the ADC read engine on the other side of the analog path
   localparam int DAC_DATA_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_LOAD  = 3'd4,
      ST_GAP   = 3'd5
   } dac_state_e;

   // Plain constants for the state register, taken from the enum above
   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_SETUP = ST_SETUP;
   localparam logic [2:0] S_SHIFT = ST_SHIFT;
   localparam logic [2:0] S_HOLD  = ST_HOLD;
   localparam logic [2:0] S_LOAD  = ST_LOAD;
   localparam logic [2:0] S_GAP   = ST_GAP;

endpackage

// File: rtl/dac_sclk_gen.sv
// dac_sclk_gen: serial clock generator for the DAC. Each half-period lasts
// CLK_DIV system clocks. The clock idles low and restarts at the beginning of a
// low phase whenever it is re-enabled. o_fall flags the last cycle of a high phase.
module dac_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_sclk,
   output logic o_fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_sclk;
   logic          w_wrap;

   assign w_wrap = i_en && (r_cnt == HALF_LAST);

   // Half-period counter; the serial clock toggles at each wrap
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (!i_en) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (w_wrap) begin
         r_cnt  <= '0;
         r_sclk <= ~r_sclk;
      end else begin
         r_cnt  <= r_cnt + CW'(1);
      end
   end

   assign o_sclk = r_sclk;
   assign o_fall = w_wrap & r_sclk;

endmodule

// File: rtl/dac_spi_writer.sv
// dac_spi_writer: captures a value on a LATCH rising edge, shifts it MSB-first
// to an SPI DAC and then strobes LDAC. A one-deep pending slot queues a request
// that arrives while a frame is in progress.
module dac_spi_writer
   import dac_pkg::*;
#(
   parameter int DATA_WIDTH = DAC_DATA_WIDTH,
   parameter int CLK_DIV    = 4,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 2,
   parameter int LDAC_WIDTH = 2,
   parameter int CS_IDLE    = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_latch,
   input  logic [DATA_WIDTH-1:0] i_value,
   output logic                  o_cs_dac,
   output logic                  o_clk_dac,
   output logic                  o_sdo_dac,
   output logic                  o_ldac_dac,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_overrun
);

   localparam int CNT_W = 16;
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LDAC_WIDTH - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_IDLE - 1);
   localparam logic [BIT_W-1:0] BIT_TOP    = BIT_W'(DATA_WIDTH - 1);

   logic [2:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [BIT_W-1:0]      r_bit;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_pend_val;
   logic                  r_pend;
   logic                  r_latch_q;
   logic                  r_cs;
   logic                  r_sdo;
   logic                  r_ldac;
   logic                  r_overrun;

   logic                  w_edge;
   logic                  w_gap_exit;
   logic                  w_sclk;
   logic                  w_fall;
   logic [DATA_WIDTH-1:0] w_shift_nxt;
   logic [DATA_WIDTH-1:0] w_start_val;

   assign w_edge      = i_latch & ~r_latch_q;
   assign w_gap_exit  = (r_state == S_GAP) && (r_cnt == GAP_LAST);
   assign w_shift_nxt = r_shift << 1;
   // A fresh edge on the GAP exit cycle beats the queued value
   assign w_start_val = w_edge ? i_value : r_pend_val;

   dac_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (r_state == S_SHIFT),
      .o_sclk (w_sclk),
      .o_fall (w_fall)
   );

   // LATCH history for rising-edge detection
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_latch_q <= 1'b0;
      else       r_latch_q <= i_latch;
   end

   // Frame sequencer: phase/bit counters, shift register, pending slot and pin drivers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_pend_val <= '0;
         r_pend     <= 1'b0;
         r_cs       <= 1'b1;
         r_sdo      <= 1'b0;
         r_ldac     <= 1'b1;
         r_overrun  <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         // Requests landing mid-frame go to the pending slot; the GAP exit cycle is handled below
         if (w_edge && (r_state != S_IDLE) && !w_gap_exit) begin
            r_pend     <= 1'b1;
            r_pend_val <= i_value;
            r_overrun  <= r_pend;
         end
         case (r_state)
            S_IDLE: begin
               if (w_edge) begin
                  r_shift <= i_value;
                  r_sdo   <= i_value[DATA_WIDTH-1];
                  r_cs    <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  r_cnt   <= '0;
                  r_bit   <= BIT_TOP;
                  r_state <= S_SHIFT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_SHIFT: begin
               // Data moves only as the serial clock falls; bit 0 stays on the pin through HOLD
               if (w_fall) begin
                  if (r_bit == '0) begin
                     r_cnt   <= '0;
                     r_state <= S_HOLD;
                  end else begin
                     r_bit   <= r_bit - BIT_W'(1);
                     r_shift <= w_shift_nxt;
                     r_sdo   <= w_shift_nxt[DATA_WIDTH-1];
                  end
               end
            end
            S_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_cs    <= 1'b1;
                  r_sdo   <= 1'b0;
                  r_ldac  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_LOAD;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_LOAD: begin
               if (r_cnt == LOAD_LAST) begin
                  r_ldac  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_GAP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_GAP: begin
               if (w_gap_exit) begin
                  if (w_edge || r_pend) begin
                     r_shift   <= w_start_val;
                     r_sdo     <= w_start_val[DATA_WIDTH-1];
                     r_cs      <= 1'b0;
                     r_cnt     <= '0;
                     r_pend    <= 1'b0;
                     r_overrun <= w_edge & r_pend;
                     r_state   <= S_SETUP;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_cs_dac   = r_cs;
   assign o_clk_dac  = w_sclk;
   assign o_sdo_dac  = r_sdo;
   assign o_ldac_dac = r_ldac;
   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = w_gap_exit;
   assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_dac_spi_writer.sv
// tb_dac_spi_writer: scenario tasks drive LATCH/VALUE and check timing inline;
// a pin-level monitor decodes each SPI frame and compares it against the queue
// of values the scenarios expect to be written.
module tb_dac_spi_writer;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_latch = 1'b0;
   logic [15:0] i_value = 16'h0000;
   logic        o_cs_dac, o_clk_dac, o_sdo_dac, o_ldac_dac, o_busy, o_done, o_overrun;

   int total = 0;
   int bad = 0;
   logic [15:0] exp_q[$];

   dac_spi_writer dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_latch    (i_latch),
      .i_value    (i_value),
      .o_cs_dac   (o_cs_dac),
      .o_clk_dac  (o_clk_dac),
      .o_sdo_dac  (o_sdo_dac),
      .o_ldac_dac (o_ldac_dac),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_overrun  (o_overrun)
   );

   always #5 i_clk = ~i_clk;

   // Frame monitor: decodes SDO at CLK_DAC rises, checks per-frame shape, pops the scoreboard
   logic        m_in = 1'b0, m_prev_cs = 1'b1, m_prev_clk = 1'b0, m_bit = 1'b0;
   int          m_bits = 0, m_cslow = 0;
   logic [15:0] m_data = 16'h0000, m_exp;
   initial begin
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            m_in = 1'b0; m_bits = 0; m_cslow = 0; m_prev_cs = 1'b1; m_prev_clk = 1'b0;
         end else begin
            if (m_prev_cs && !o_cs_dac) begin
               m_in = 1'b1; m_bits = 0; m_cslow = 0; m_data = 16'h0000;
            end
            if (!o_cs_dac) m_cslow++;
            if (!o_ldac_dac) begin
               total++;
               if (!o_cs_dac) begin bad++; $display("FAIL ldac_vs_cs: ldac=0 while cs=0 at %0t", $time); end
            end
            if (o_clk_dac && !m_prev_clk) begin
               m_data = {m_data[14:0], o_sdo_dac}; m_bits++; m_bit = o_sdo_dac;
            end else if (o_clk_dac && m_prev_clk) begin
               total++;
               if (o_sdo_dac !== m_bit) begin bad++; $display("FAIL sdo_stable: got %b want %b at %0t", o_sdo_dac, m_bit, $time); end
            end
            if (m_in && o_cs_dac) begin
               m_in = 1'b0;
               total++;
               if (m_bits != 16) begin bad++; $display("FAIL frame_bits: got %0d want 16", m_bits); end
               total++;
               if (m_cslow != 132) begin bad++; $display("FAIL cs_low_len: got %0d want 132", m_cslow); end
               total++;
               if (exp_q.size() == 0) begin
                  bad++; $display("FAIL frame_unexpected: got %h want none", m_data);
               end else begin
                  m_exp = exp_q.pop_front();
                  if (m_data !== m_exp) begin bad++; $display("FAIL frame_data: got %h want %h", m_data, m_exp); end
               end
            end
            m_prev_cs = o_cs_dac; m_prev_clk = o_clk_dac;
         end
      end
   end

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      total++;
      if ({o_cs_dac, o_clk_dac, o_sdo_dac, o_ldac_dac, o_busy, o_done, o_overrun} !== 7'b1001000) begin
         bad++; $display("FAIL reset_outputs: got %b want 1001000",
                         {o_cs_dac, o_clk_dac, o_sdo_dac, o_ldac_dac, o_busy, o_done, o_overrun});
      end
      #1 i_rst = 1'b0;
      repeat (2) @(negedge i_clk);
      total++;
      if ({o_cs_dac, o_ldac_dac, o_busy} !== 3'b110) begin
         bad++; $display("FAIL idle_after_reset: got %b want 110", {o_cs_dac, o_ldac_dac, o_busy});
      end
   endtask

   task automatic test_single();
      int cs_fall = -1, first_rise = -1, rises = 0, busy_cnt = 0, done_cyc = -1, ldac_first = -1, ldac_cnt = 0;
      logic pclk = 1'b0;
      @(negedge i_clk);
      i_value = 16'hA5C3; i_latch = 1'b1; exp_q.push_back(16'hA5C3);
      for (int c = 1; c <= 300; c++) begin
         @(negedge i_clk);
         if (c == 1) i_latch = 1'b0;
         if (!o_cs_dac && cs_fall < 0) cs_fall = c;
         if (o_clk_dac && !pclk) begin rises++; if (first_rise < 0) first_rise = c; end
         pclk = o_clk_dac;
         if (o_busy) busy_cnt++;
         if (o_done && done_cyc < 0) done_cyc = c;
         if (!o_ldac_dac) begin ldac_cnt++; if (ldac_first < 0) ldac_first = c; end
      end
      total++; if (cs_fall != 1)      begin bad++; $display("FAIL cs_fall_cycle: got %0d want 1", cs_fall); end
      total++; if (first_rise != 7)   begin bad++; $display("FAIL first_rise: got %0d want 7", first_rise); end
      total++; if (rises != 16)       begin bad++; $display("FAIL rise_count: got %0d want 16", rises); end
      total++; if (busy_cnt != 138)   begin bad++; $display("FAIL busy_len: got %0d want 138", busy_cnt); end
      total++; if (done_cyc != 138)   begin bad++; $display("FAIL done_cycle: got %0d want 138", done_cyc); end
      total++; if (ldac_first != 133) begin bad++; $display("FAIL ldac_start: got %0d want 133", ldac_first); end
      total++; if (ldac_cnt != 2)     begin bad++; $display("FAIL ldac_len: got %0d want 2", ldac_cnt); end
   endtask

   task automatic test_constant(input logic [15:0] val);
      int diff = 0, low = 0;
      @(negedge i_clk);
      i_value = val; i_latch = 1'b1; exp_q.push_back(val);
      for (int c = 1; c <= 160; c++) begin
         @(negedge i_clk);
         if (c == 1) i_latch = 1'b0;
         if (!o_cs_dac) begin low++; if (o_sdo_dac !== val[15]) diff++; end
      end
      total++; if (diff != 0)  begin bad++; $display("FAIL const_sdo_%h: got %0d changes want 0", val, diff); end
      total++; if (low != 132) begin bad++; $display("FAIL const_cs_%h: got %0d want 132", val, low); end
   endtask

   task automatic test_back_to_back();
      int busy_cnt = 0, dones = 0, ovr = 0, falls = 0, gap = 0;
      logic pcs = 1'b1, was_low = 1'b0;
      @(negedge i_clk);
      i_value = 16'hBEEF; i_latch = 1'b1; exp_q.push_back(16'hBEEF);
      for (int c = 1; c <= 400; c++) begin
         @(negedge i_clk);
         if (c == 1 || c == 51) i_latch = 1'b0;
         if (c == 50) begin i_value = 16'h1234; i_latch = 1'b1; exp_q.push_back(16'h1234); end
         if (pcs && !o_cs_dac) falls++;
         if (!o_cs_dac) was_low = 1'b1;
         if (falls == 1 && was_low && o_cs_dac) gap++;
         pcs = o_cs_dac;
         if (o_busy) busy_cnt++;
         if (o_done) dones++;
         if (o_overrun) ovr++;
      end
      total++; if (falls != 2)      begin bad++; $display("FAIL b2b_frames: got %0d want 2", falls); end
      total++; if (gap != 6)        begin bad++; $display("FAIL b2b_cs_gap: got %0d want 6", gap); end
      total++; if (busy_cnt != 276) begin bad++; $display("FAIL b2b_busy: got %0d want 276", busy_cnt); end
      total++; if (dones != 2)      begin bad++; $display("FAIL b2b_done: got %0d want 2", dones); end
      total++; if (ovr != 0)        begin bad++; $display("FAIL b2b_overrun: got %0d want 0", ovr); end
   endtask

   task automatic test_overrun();
      int ovr = 0, ovr_cyc = -1, falls = 0, dones = 0;
      logic pcs = 1'b1;
      @(negedge i_clk);
      i_value = 16'h5A5A; i_latch = 1'b1; exp_q.push_back(16'h5A5A);
      for (int c = 1; c <= 400; c++) begin
         @(negedge i_clk);
         if (c == 1 || c == 41 || c == 61) i_latch = 1'b0;
         if (c == 40) begin i_value = 16'h1111; i_latch = 1'b1; end
         if (c == 60) begin i_value = 16'h2222; i_latch = 1'b1; exp_q.push_back(16'h2222); end
         if (pcs && !o_cs_dac) falls++;
         pcs = o_cs_dac;
         if (o_overrun) begin ovr++; if (ovr_cyc < 0) ovr_cyc = c; end
         if (o_done) dones++;
      end
      total++; if (ovr != 1)      begin bad++; $display("FAIL ovr_count: got %0d want 1", ovr); end
      total++; if (ovr_cyc != 61) begin bad++; $display("FAIL ovr_cycle: got %0d want 61", ovr_cyc); end
      total++; if (falls != 2)    begin bad++; $display("FAIL ovr_frames: got %0d want 2", falls); end
      total++; if (dones != 2)    begin bad++; $display("FAIL ovr_done: got %0d want 2", dones); end
   endtask

   task automatic test_held();
      int falls = 0, dones = 0;
      logic pcs = 1'b1;
      @(negedge i_clk);
      i_value = 16'h3C3C; i_latch = 1'b1; exp_q.push_back(16'h3C3C);
      for (int c = 1; c <= 500; c++) begin
         @(negedge i_clk);
         if (pcs && !o_cs_dac) falls++;
         pcs = o_cs_dac;
         if (o_done) dones++;
      end
      i_latch = 1'b0;
      repeat (2) @(negedge i_clk);
      total++; if (falls != 1) begin bad++; $display("FAIL held_frames: got %0d want 1", falls); end
      total++; if (dones != 1) begin bad++; $display("FAIL held_done: got %0d want 1", dones); end
   endtask

   task automatic test_reset_mid();
      int ldac_lows = 0, cs_lows = 0, dones = 0;
      @(negedge i_clk);
      i_value = 16'h7777; i_latch = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         @(negedge i_clk);
         if (c == 1) i_latch = 1'b0;
      end
      #2 i_rst = 1'b1;
      #1;
      total++;
      if ({o_cs_dac, o_clk_dac, o_sdo_dac, o_ldac_dac, o_busy, o_done, o_overrun} !== 7'b1001000) begin
         bad++; $display("FAIL midreset_outputs: got %b want 1001000",
                         {o_cs_dac, o_clk_dac, o_sdo_dac, o_ldac_dac, o_busy, o_done, o_overrun});
      end
      @(negedge i_clk);
      #1 i_rst = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge i_clk);
         if (!o_ldac_dac) ldac_lows++;
         if (!o_cs_dac) cs_lows++;
      end
      total++; if (ldac_lows != 0) begin bad++; $display("FAIL midreset_ldac: got %0d want 0", ldac_lows); end
      total++; if (cs_lows != 0)   begin bad++; $display("FAIL midreset_cs: got %0d want 0", cs_lows); end
      @(negedge i_clk);
      i_value = 16'h0F0F; i_latch = 1'b1; exp_q.push_back(16'h0F0F);
      for (int c = 1; c <= 200; c++) begin
         @(negedge i_clk);
         if (c == 1) i_latch = 1'b0;
         if (o_done) dones++;
      end
      total++; if (dones != 1) begin bad++; $display("FAIL postreset_done: got %0d want 1", dones); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_constant(16'hFFFF);
      test_constant(16'h0000);
      test_back_to_back();
      test_overrun();
      test_held();
      test_reset_mid();
      repeat (5) @(negedge i_clk);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL frames_outstanding: got %0d want 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
